// File: rtl/bp_me_dma_bank_arbiter_pkg.sv
// Shared types and helpers for the per-bank DMA arbiter slice.
package bp_me_dma_bank_arbiter_pkg;

  typedef enum logic {
    e_dma_read  = 1'b0,
    e_dma_write = 1'b1
  } dma_dir_e;

  // Width of an index into n items; never zero so single-entry cases stay legal.
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_me_dma_burst_tracker.sv
// Bank-id FIFO in pkt acceptance order plus a beat counter that pops the head
// after the last beat of its burst.
module bp_me_dma_burst_tracker
  import bp_me_dma_bank_arbiter_pkg::*;
#(
  parameter int unsigned id_width_p  = 1,
  parameter int unsigned els_p       = 4,
  parameter int unsigned burst_len_p = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  push_v_i,
  input  logic [id_width_p-1:0] push_id_i,
  input  logic                  beat_v_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [id_width_p-1:0] head_id_o
);

  localparam int unsigned ptr_w = safe_clog2(els_p);
  localparam int unsigned cnt_w = safe_clog2(burst_len_p);
  localparam int unsigned num_w = $clog2(els_p + 1);

  logic [id_width_p-1:0] mem_q [els_p];
  logic [ptr_w-1:0]      rd_ptr_q, wr_ptr_q;
  logic [num_w-1:0]      num_q;
  logic [cnt_w-1:0]      beat_q;
  logic                  push, beat, last_beat, pop;

  assign full_o    = (num_q == num_w'(els_p));
  assign empty_o   = (num_q == '0);
  assign head_id_o = mem_q[rd_ptr_q];

  assign push      = push_v_i && !full_o;
  assign beat      = beat_v_i && !empty_o;
  assign last_beat = (beat_q == cnt_w'(burst_len_p - 1));
  assign pop       = beat && last_beat;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_id_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      num_q    <= '0;
      beat_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == ptr_w'(els_p - 1)) ? '0 : wr_ptr_q + ptr_w'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == ptr_w'(els_p - 1)) ? '0 : rd_ptr_q + ptr_w'(1);
      end
      case ({push, pop})
        2'b10:   num_q <= num_q + num_w'(1);
        2'b01:   num_q <= num_q - num_w'(1);
        default: num_q <= num_q;
      endcase
      if (beat) begin
        beat_q <= last_beat ? '0 : beat_q + cnt_w'(1);
      end
    end
  end

endmodule

// File: rtl/bp_me_dma_bank_arbiter.sv
// Merges per-bank L2 DMA channels onto one DRAM DMA port: round-robin pkt
// arbitration with grant lock, in-order read return and write-data steering.
module bp_me_dma_bank_arbiter
  import bp_me_dma_bank_arbiter_pkg::*;
#(
  parameter int unsigned num_banks_p       = 2,
  parameter int unsigned dma_pkt_width_p   = 40,
  parameter int unsigned dma_data_width_p  = 64,
  parameter int unsigned burst_len_p       = 8,
  parameter int unsigned max_outstanding_p = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,

  input  logic [num_banks_p*dma_pkt_width_p-1:0] bank_pkt_i,
  input  logic [num_banks_p-1:0]                 bank_pkt_v_i,
  output logic [num_banks_p-1:0]                 bank_pkt_ready_and_o,

  output logic [num_banks_p*dma_data_width_p-1:0] bank_data_o,
  output logic [num_banks_p-1:0]                  bank_data_v_o,
  input  logic [num_banks_p-1:0]                  bank_data_ready_and_i,

  input  logic [num_banks_p*dma_data_width_p-1:0] bank_data_i,
  input  logic [num_banks_p-1:0]                  bank_data_v_i,
  output logic [num_banks_p-1:0]                  bank_data_ready_and_o,

  output logic [dma_pkt_width_p-1:0]             dma_pkt_o,
  output logic                                   dma_pkt_v_o,
  input  logic                                   dma_pkt_ready_and_i,

  input  logic [dma_data_width_p-1:0]            dma_data_i,
  input  logic                                   dma_data_v_i,
  output logic                                   dma_data_ready_and_o,

  output logic [dma_data_width_p-1:0]            dma_data_o,
  output logic                                   dma_data_v_o,
  input  logic                                   dma_data_ready_and_i
);

  localparam int unsigned id_w = safe_clog2(num_banks_p);

  logic [id_w-1:0]        rr_q, lock_id_q, grant_id, cand;
  logic                   lock_v_q, grant_v, pkt_hs;
  logic [num_banks_p-1:0] eligible;
  dma_dir_e               grant_dir;

  logic            rd_full, rd_empty, wr_full, wr_empty;
  logic [id_w-1:0] rd_head, wr_head;
  logic            rd_active, wr_active, rd_push, wr_push, rd_beat, wr_beat;

  // A bank only competes when the tracker for its direction has room.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < num_banks_p; i++) begin
      eligible[i] = bank_pkt_v_i[i] && !reset_i
                 && (bank_pkt_i[i*dma_pkt_width_p + dma_pkt_width_p - 1] ? !wr_full : !rd_full);
    end
  end

  always_comb begin
    grant_v  = 1'b0;
    grant_id = '0;
    cand     = '0;
    if (lock_v_q) begin
      grant_id = lock_id_q;
      grant_v  = eligible[lock_id_q];
    end else begin
      for (int unsigned off = 0; off < num_banks_p; off++) begin
        cand = id_w'((off + 32'(rr_q)) % num_banks_p);
        if (!grant_v && eligible[cand]) begin
          grant_v  = 1'b1;
          grant_id = cand;
        end
      end
    end
  end

  always_comb begin
    dma_pkt_o            = '0;
    bank_pkt_ready_and_o = '0;
    for (int unsigned i = 0; i < num_banks_p; i++) begin
      if (grant_id == id_w'(i)) begin
        dma_pkt_o               = bank_pkt_i[i*dma_pkt_width_p +: dma_pkt_width_p];
        bank_pkt_ready_and_o[i] = pkt_hs;
      end
    end
  end

  assign dma_pkt_v_o = grant_v;
  assign pkt_hs      = grant_v && dma_pkt_ready_and_i;
  assign grant_dir   = dma_dir_e'(dma_pkt_o[dma_pkt_width_p-1]);
  assign rd_push     = pkt_hs && (grant_dir == e_dma_read);
  assign wr_push     = pkt_hs && (grant_dir == e_dma_write);

  // An offered pkt without handshake pins the grant so dma_pkt_o stays stable.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_q      <= '0;
      lock_v_q  <= 1'b0;
      lock_id_q <= '0;
    end else if (pkt_hs) begin
      lock_v_q <= 1'b0;
      rr_q     <= (grant_id == id_w'(num_banks_p - 1)) ? '0 : grant_id + id_w'(1);
    end else if (grant_v) begin
      lock_v_q  <= 1'b1;
      lock_id_q <= grant_id;
    end
  end

  assign rd_active = !rd_empty && !reset_i;
  assign wr_active = !wr_empty && !reset_i;

  always_comb begin
    bank_data_o           = '0;
    bank_data_v_o         = '0;
    dma_data_ready_and_o  = 1'b0;
    dma_data_o            = '0;
    dma_data_v_o          = 1'b0;
    bank_data_ready_and_o = '0;
    for (int unsigned i = 0; i < num_banks_p; i++) begin
      bank_data_o[i*dma_data_width_p +: dma_data_width_p] = dma_data_i;
      if (rd_head == id_w'(i)) begin
        bank_data_v_o[i]     = rd_active && dma_data_v_i;
        dma_data_ready_and_o = rd_active && bank_data_ready_and_i[i];
      end
      if (wr_head == id_w'(i)) begin
        dma_data_o               = bank_data_i[i*dma_data_width_p +: dma_data_width_p];
        dma_data_v_o             = wr_active && bank_data_v_i[i];
        bank_data_ready_and_o[i] = wr_active && dma_data_ready_and_i;
      end
    end
  end

  assign rd_beat = dma_data_v_i && dma_data_ready_and_o;
  assign wr_beat = dma_data_v_o && dma_data_ready_and_i;

  bp_me_dma_burst_tracker #(
    .id_width_p  (id_w),
    .els_p       (max_outstanding_p),
    .burst_len_p (burst_len_p)
  ) rd_tracker (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .push_v_i  (rd_push),
    .push_id_i (grant_id),
    .beat_v_i  (rd_beat),
    .full_o    (rd_full),
    .empty_o   (rd_empty),
    .head_id_o (rd_head)
  );

  bp_me_dma_burst_tracker #(
    .id_width_p  (id_w),
    .els_p       (max_outstanding_p),
    .burst_len_p (burst_len_p)
  ) wr_tracker (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .push_v_i  (wr_push),
    .push_id_i (grant_id),
    .beat_v_i  (wr_beat),
    .full_o    (wr_full),
    .empty_o   (wr_empty),
    .head_id_o (wr_head)
  );

endmodule
